// File: rtl/egg_timer_datapath.sv
// rtl/egg_timer_datapath.sv - egg timer countdown datapath with BCD digits and flash blanking
// Optional feature: define DONE_PULSE_EN to add the donePulse output.
module egg_timer_datapath #(
   parameter int TICK_DIV   = 50000000,
   parameter int FLASH_HALF = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] sw,
   input  logic       swSecEn,
   input  logic       swMinEn,
   input  logic       decEn,
   input  logic       flashEn,
   output logic       isTimeFlat,
   output logic [3:0] minTens,
   output logic [3:0] minOnes,
   output logic [3:0] secTens,
   output logic [3:0] secOnes,
   output logic       blank
`ifdef DONE_PULSE_EN
   ,
   output logic       donePulse
`endif
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

   logic [5:0]    secs, secs_nxt;
   logic [6:0]    mins, mins_nxt;
   logic [TW-1:0] tickCnt;
   logic [FW-1:0] flashCnt;
   logic          tick;
   logic [5:0]    sw_sec;
   logic [6:0]    sw_min;

   assign tick   = decEn && (tickCnt == TICK_LAST);
   assign sw_sec = (sw > 7'd59) ? 6'd59 : sw[5:0];
   assign sw_min = (sw > 7'd99) ? 7'd99 : sw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tickCnt <= '0;
      else if (!decEn || tick)
         tickCnt <= '0;
      else
         tickCnt <= tickCnt + 1'b1;
   end

   // Loads override the decrement per field; a seconds load also blocks the minutes borrow.
   always_comb begin
      secs_nxt = secs;
      mins_nxt = mins;
      if (tick) begin
         if (secs != 6'd0) begin
            secs_nxt = secs - 6'd1;
         end else if (mins != 7'd0) begin
            secs_nxt = 6'd59;
            mins_nxt = mins - 7'd1;
         end
      end
      if (swSecEn) begin
         secs_nxt = sw_sec;
         mins_nxt = mins;
      end else if (swMinEn) begin
         mins_nxt = sw_min;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         secs <= '0;
         mins <= '0;
      end else begin
         secs <= secs_nxt;
         mins <= mins_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flashCnt <= '0;
         blank    <= 1'b0;
      end else if (!flashEn) begin
         flashCnt <= '0;
         blank    <= 1'b0;
      end else if (flashCnt == FLASH_LAST) begin
         flashCnt <= '0;
         blank    <= ~blank;
      end else begin
         flashCnt <= flashCnt + 1'b1;
      end
   end

`ifdef DONE_PULSE_EN
   // Only a genuine countdown from 0:01 fires; loads and idle ticks at 0:00 do not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         donePulse <= 1'b0;
      else
         donePulse <= tick && !swSecEn && !swMinEn && (mins == 7'd0) && (secs == 6'd1);
   end
`endif

   assign isTimeFlat = (mins == 7'd0) && (secs == 6'd0);
   assign minTens    = 4'(mins / 7'd10);
   assign minOnes    = 4'(mins % 7'd10);
   assign secTens    = 4'(secs / 6'd10);
   assign secOnes    = 4'(secs % 6'd10);

endmodule

// File: tb/tb_egg_timer_datapath.sv
// tb/tb_egg_timer_datapath.sv - self-checking bench for egg_timer_datapath
// Reference model works on total seconds and run lengths of the enables.
module tb_egg_timer_datapath;
   localparam int TICK_DIV   = 4;
   localparam int FLASH_HALF = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] sw = '0;
   logic       swSecEn = 1'b0, swMinEn = 1'b0, decEn = 1'b0, flashEn = 1'b0;
   logic       isTimeFlat, blank;
   logic [3:0] minTens, minOnes, secTens, secOnes;
`ifdef DONE_PULSE_EN
   logic       donePulse;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   int m_secs = 0, m_mins = 0, m_run = 0, m_fl = 0, m_blank = 0, m_done = 0;

   egg_timer_datapath #(.TICK_DIV(TICK_DIV), .FLASH_HALF(FLASH_HALF)) dut (
      .clk(clk), .reset(reset), .sw(sw), .swSecEn(swSecEn), .swMinEn(swMinEn),
      .decEn(decEn), .flashEn(flashEn), .isTimeFlat(isTimeFlat),
      .minTens(minTens), .minOnes(minOnes), .secTens(secTens), .secOnes(secOnes),
      .blank(blank)
`ifdef DONE_PULSE_EN
      , .donePulse(donePulse)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_secs <= 0; m_mins <= 0; m_run <= 0; m_fl <= 0; m_blank <= 0; m_done <= 0;
      end else begin
         int t, d, run, fl;
         logic tick;
         run  = decEn ? m_run + 1 : 0;
         tick = decEn && (run % TICK_DIV == 0);
         t    = m_mins * 60 + m_secs;
         d    = (tick && t > 0) ? t - 1 : t;
         if (swSecEn) begin
            m_secs <= (sw > 59) ? 59 : int'(sw);
         end else if (swMinEn) begin
            m_mins <= (sw > 99) ? 99 : int'(sw);
            m_secs <= d % 60;
         end else begin
            m_mins <= d / 60;
            m_secs <= d % 60;
         end
         m_done  <= (tick && !swSecEn && !swMinEn && t == 1) ? 1 : 0;
         m_run   <= run;
         fl       = flashEn ? m_fl + 1 : 0;
         m_fl    <= fl;
         m_blank <= flashEn ? (fl / FLASH_HALF) % 2 : 0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("isTimeFlat", int'(isTimeFlat), (m_mins == 0 && m_secs == 0) ? 1 : 0);
         chk("minTens", int'(minTens), m_mins / 10);
         chk("minOnes", int'(minOnes), m_mins % 10);
         chk("secTens", int'(secTens), m_secs / 10);
         chk("secOnes", int'(secOnes), m_secs % 10);
         chk("blank", int'(blank), m_blank);
`ifdef DONE_PULSE_EN
         chk("donePulse", int'(donePulse), m_done);
`endif
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load(input logic sec, input logic [6:0] v);
      sw = v; swSecEn = sec; swMinEn = !sec;
      cyc(1);
      swSecEn = 1'b0; swMinEn = 1'b0;
   endtask

   initial begin
      int blank_exp [8];
      int pulses;
      blank_exp = '{0, 0, 1, 1, 0, 0, 1, 1};

      cyc(2);
      reset = 1'b0;
      cyc(1);
      chk("rst_flat", int'(isTimeFlat), 1);
      chk("rst_digits", int'({minTens, minOnes, secTens, secOnes}), 0);
      chk("rst_blank", int'(blank), 0);

      // load then async reset mid-cycle
      load(1'b0, 7'd5);
      load(1'b1, 7'd30);
      chk("t1_minOnes", int'(minOnes), 5);
      chk("t1_secTens", int'(secTens), 3);
      #1 reset = 1'b1;
      #1;
      chk("t1_flat", int'(isTimeFlat), 1);
      chk("t1_digits", int'({minTens, minOnes, secTens, secOnes}), 0);
      chk("t1_blank", int'(blank), 0);
      cyc(1);
      reset = 1'b0;
      cyc(1);

      // loads and saturation
      load(1'b1, 7'd75);
      chk("t2_secTens", int'(secTens), 5);
      chk("t2_secOnes", int'(secOnes), 9);
      load(1'b0, 7'd120);
      chk("t2_min_sat", int'({minTens, minOnes}), 8'h99);
      load(1'b0, 7'd12);
      chk("t2_min12", int'({minTens, minOnes}), 8'h12);
      sw = 7'd7; swSecEn = 1'b1; swMinEn = 1'b1;
      cyc(1);
      swSecEn = 1'b0; swMinEn = 1'b0;
      chk("t2_both_sec", int'({secTens, secOnes}), 8'h07);
      chk("t2_both_min", int'({minTens, minOnes}), 8'h12);

      // borrow from 1:00
      load(1'b0, 7'd1);
      load(1'b1, 7'd0);
      decEn = 1'b1;
      cyc(3);
      chk("t3_hold", int'({minOnes, secTens, secOnes}), 12'h100);
      cyc(1);
      chk("t3_borrow", int'({minOnes, secTens, secOnes}), 12'h059);
      chk("t3_flat", int'(isTimeFlat), 0);
      cyc(4);
      chk("t3_58", int'({secTens, secOnes}), 8'h58);
      decEn = 1'b0;

      // count to zero and hold
      load(1'b0, 7'd0);
      load(1'b1, 7'd1);
      decEn = 1'b1;
      cyc(3);
      chk("t4_not_yet", int'(isTimeFlat), 0);
      pulses = 0;
      cyc(1);
      chk("t4_flat", int'(isTimeFlat), 1);
`ifdef DONE_PULSE_EN
      chk("t4_pulse", int'(donePulse), 1);
      pulses += int'(donePulse);
`endif
      for (int i = 0; i < 8; i++) begin
         cyc(1);
`ifdef DONE_PULSE_EN
         pulses += int'(donePulse);
`endif
      end
      chk("t4_hold", int'({isTimeFlat, minTens, minOnes, secTens, secOnes}), 17'h10000);
`ifdef DONE_PULSE_EN
      chk("t4_pulse_count", pulses, 1);
`endif
      decEn = 1'b0;

      // flash blink
      flashEn = 1'b1;
      chk("t5_blank0", int'(blank), blank_exp[0]);
      for (int i = 1; i < 8; i++) begin
         cyc(1);
         chk("t5_blank", int'(blank), blank_exp[i]);
      end
      cyc(1);
      cyc(2);
      chk("t5_blank_on", int'(blank), 1);
      flashEn = 1'b0;
      cyc(1);
      chk("t5_drop", int'(blank), 0);

      // pause and resume
      load(1'b1, 7'd10);
      decEn = 1'b1;
      cyc(2);
      decEn = 1'b0;
      cyc(3);
      chk("t6_paused", int'({secTens, secOnes}), 8'h10);
      decEn = 1'b1;
      cyc(3);
      chk("t6_not_yet", int'({secTens, secOnes}), 8'h10);
      cyc(1);
      chk("t6_nine", int'({secTens, secOnes}), 8'h09);
      decEn = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/egg_timer_datapath.md
Name: egg_timer_datapath

Overview:
Countdown datapath driven by the egg-timer controller's enables. It consumes swSecEn/swMinEn/decEn/flashEn and returns isTimeFlat.
- Loads minutes and seconds from the switches.
- Decrements once per second while enabled.
- Produces BCD digits for the 7-segment drivers, plus a display-blank signal for flashing.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second decrement tick (bench uses 4)
FLASH_HALF, 25000000, clk cycles per half-period of the flash blink (bench uses 2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
sw  input  7  unsigned binary switch value for loading
swSecEn  input  1  load seconds from sw
swMinEn  input  1  load minutes from sw
decEn  input  1  countdown running
flashEn  input  1  blink display (timer expired)
isTimeFlat  output  1  high when mins==0 and secs==0
minTens  output  4  BCD tens of minutes
minOnes  output  4  BCD ones of minutes
secTens  output  4  BCD tens of seconds
secOnes  output  4  BCD ones of seconds
blank  output  1  1 = display off (flash phase)

Behaviour:
- Registers:
  - secs: 6 bits, range 0-59.
  - mins: 7 bits, range 0-99.
  - tickCnt: counts 0..TICK_DIV-1.
  - flashCnt: counts 0..FLASH_HALF-1.
  - blank: 1 bit.
- Reset (async, any time, including mid-countdown): secs=0, mins=0, tickCnt=0, flashCnt=0, blank=0.
  - Outputs after reset: isTimeFlat=1, all BCD digits 0.
- Loading:
  - swSecEn=1 → secs <= min(sw,59) on every rising edge (live tracking of switches).
  - swMinEn=1 → mins <= min(sw,99) on every rising edge.
  - Both high in the same cycle → swSecEn wins; mins holds.
  - Saturation examples: sw=75 loads secs=59; sw=120 loads mins=99.
- Tick generation:
  - decEn=0 → tickCnt cleared to 0.
  - decEn=1 → tickCnt increments and wraps at TICK_DIV-1; tick is high in the wrap cycle.
  - First decrement lands on the TICK_DIV-th rising edge after decEn first samples high.
- Decrement, on a tick edge with decEn=1:
  - secs>0 → secs-1.
  - secs==0 and mins>0 → mins-1, secs=59.
  - 0:00 → hold. No wrap below zero; tickCnt keeps running.
- Priority: a load (swSecEn/swMinEn) in the same cycle as a tick overrides the decrement for the loaded field. The other field still decrements.
  - Exception: a secs borrow is suppressed if secs is being loaded.
- isTimeFlat: combinational from registered mins/secs. It asserts the same cycle the registers reach 0:00.
- BCD outputs: combinational divide/mod-10 of secs and mins.
- Flash:
  - flashEn=0 → flashCnt=0, blank=0.
  - flashEn=1 → flashCnt counts; blank toggles each time flashCnt wraps at FLASH_HALF-1. The first FLASH_HALF cycles show the display (blank=0).
  - Flash is independent of decEn and loads.
- No other state machine; all sequencing is owned by the controller.

Optional Feature:
Macro DONE_PULSE_EN.
- Defined: adds output port donePulse (1 bit, reset 0).
  - Registered one-cycle pulse in the cycle after the decrement transition from 0:01 to 0:00.
  - No pulse when 0:00 is reached by a load.
  - No pulse when ticks occur while already at 0:00.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
All cases use TICK_DIV=4 and FLASH_HALF=2.
1. Load then reset: load mins=5/secs=30, then assert reset mid-cycle → immediately mins=secs=0, isTimeFlat=1, blank=0, all digits 0.
2. Load and saturate: swSecEn with sw=75 → secs=59 (secTens=5, secOnes=9). swMinEn with sw=12 → mins=12 (1,2). Both enables with sw=7 → secs=7, mins stays 12.
3. Borrow: mins=1, secs=0, raise decEn → 4th edge gives 0:59, isTimeFlat=0. 4 more edges give 0:58.
4. Count to zero: mins=0, secs=1, decEn=1 → 4th edge gives 0:00 and isTimeFlat=1 that cycle. 8 more edges hold 0:00. With DONE_PULSE_EN, donePulse is high exactly 1 cycle.
5. Flash: flashEn=1 for 8 edges → blank sequence 0,0,1,1,0,0,1,1. Drop flashEn → blank=0 next edge.
6. Pause: decEn low after 2 counts at secs=10, then re-raised → no decrement until 4 edges after re-rise, then secs=9.
